hack_cpu_ctrl: RTL and testbench

HACK_CPU_CTRL -- requirements
Module: hack_cpu_ctrl

---
 rtl/hack_cpu_ctrl_pkg.sv | 31 +++
 rtl/hack_cpu_ctrl_if.sv | 26 ++
 rtl/hack_cpu_ctrl_alu.sv | 32 +++
 rtl/hack_cpu_ctrl.sv | 108 ++++++++++
 tb/tb_hack_cpu_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_cpu_ctrl_pkg.sv
// rtl/hack_cpu_ctrl_pkg.sv - shared widths, IR field positions and FSM state type for the Hack CPU controller
package hack_cpu_ctrl_pkg;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 15;

   localparam int IR_CI   = 15;
   localparam int IR_A    = 12;
   localparam int COMP_HI = 11;
   localparam int COMP_LO = 6;
   localparam int DEST_A  = 5;
   localparam int DEST_D  = 4;
   localparam int DEST_M  = 3;
   localparam int JUMP_HI = 2;
   localparam int JUMP_LO = 0;
   localparam int JMP_LT  = 2;
   localparam int JMP_EQ  = 1;
   localparam int JMP_GT  = 0;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_READ  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   function automatic logic jump_taken(input logic [2:0] jmp, input logic ng, input logic zr);
      return (jmp[JMP_LT] & ng) | (jmp[JMP_EQ] & zr) | (jmp[JMP_GT] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// rtl/hack_cpu_ctrl_if.sv - instruction fetch and data memory bus between controller and its environment
interface hack_cpu_ctrl_if;
   import hack_cpu_ctrl_pkg::*;

   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              instr_ready;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] addressM;
   logic              mem_req;
   logic              writeM;
   logic [DATA_W-1:0] outM;
   logic [DATA_W-1:0] inM;
   logic              mem_ack;

   modport master (
      input  instr, instr_valid, inM, mem_ack,
      output instr_ready, pc, addressM, mem_req, writeM, outM
   );

   modport slave (
      output instr, instr_valid, inM, mem_ack,
      input  instr_ready, pc, addressM, mem_req, writeM, outM
   );

endinterface

// File: rtl/hack_cpu_ctrl_alu.sv
// rtl/hack_cpu_ctrl_alu.sv - Hack ALU: zero/negate each input, add or and, optionally negate the result
module alu
   import hack_cpu_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic              zx,
   input  logic              nx,
   input  logic              zy,
   input  logic              ny,
   input  logic              f,
   input  logic              no,
   output logic [DATA_W-1:0] out,
   output logic              zr,
   output logic              ng
);

   logic [DATA_W-1:0] x_z, x_n, y_z, y_n, res;

   always_comb begin
      x_z = zx ? '0 : x;
      x_n = nx ? ~x_z : x_z;
      y_z = zy ? '0 : y;
      y_n = ny ? ~y_z : y_z;
      res = f ? (x_n + y_n) : (x_n & y_n);
      out = no ? ~res : res;
   end

   assign zr = (out == '0);
   assign ng = out[DATA_W-1];

endmodule

// File: rtl/hack_cpu_ctrl.sv
// rtl/hack_cpu_ctrl.sv - multi-cycle Hack CPU controller: fetch, optional M read, execute, optional M write
module hack_cpu_ctrl
   import hack_cpu_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   hack_cpu_ctrl_if.master bus
);

   state_t            state, state_nx;
   logic [DATA_W-1:0] a_reg, d_reg, ir, m_reg, outm_reg;
   logic [ADDR_W-1:0] pc_reg, addr_reg;
   logic [DATA_W-1:0] alu_y, alu_out;
   logic [5:0]        comp;
   logic              alu_zr, alu_ng, is_c, jump;
   logic              instr_ready, mem_req, writeM;

   assign is_c  = ir[IR_CI];
   assign comp  = ir[COMP_HI:COMP_LO];
   assign alu_y = ir[IR_A] ? m_reg : a_reg;
   assign jump  = jump_taken(ir[JUMP_HI:JUMP_LO], alu_ng, alu_zr);

   alu u_alu (
      .x  (d_reg),
      .y  (alu_y),
      .zx (comp[5]),
      .nx (comp[4]),
      .zy (comp[3]),
      .ny (comp[2]),
      .f  (comp[1]),
      .no (comp[0]),
      .out(alu_out),
      .zr (alu_zr),
      .ng (alu_ng)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_FETCH;
      else        state <= state_nx;
   end

   // Bus strobes decode from state only so they never depend combinationally on inputs.
   always_comb begin
      state_nx    = state;
      instr_ready = 1'b0;
      mem_req     = 1'b0;
      writeM      = 1'b0;
      case (state)
         ST_FETCH: begin
            instr_ready = 1'b1;
            if (bus.instr_valid)
               state_nx = (bus.instr[IR_CI] && bus.instr[IR_A]) ? ST_READ : ST_EXEC;
         end
         ST_READ: begin
            mem_req = 1'b1;
            if (bus.mem_ack) state_nx = ST_EXEC;
         end
         ST_EXEC: begin
            state_nx = (is_c && ir[DEST_M]) ? ST_WRITE : ST_FETCH;
         end
         ST_WRITE: begin
            mem_req = 1'b1;
            writeM  = 1'b1;
            if (bus.mem_ack) state_nx = ST_FETCH;
         end
         default: state_nx = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg    <= '0;
         d_reg    <= '0;
         pc_reg   <= '0;
         ir       <= '0;
         m_reg    <= '0;
         outm_reg <= '0;
         addr_reg <= '0;
      end else begin
         case (state)
            ST_FETCH: if (bus.instr_valid) ir <= bus.instr;
            ST_READ:  if (bus.mem_ack) m_reg <= bus.inM;
            ST_EXEC: begin
               // Write address and jump target both use A as it was before this instruction.
               addr_reg <= a_reg[ADDR_W-1:0];
               if (!is_c) begin
                  a_reg  <= ir;
                  pc_reg <= pc_reg + ADDR_W'(1);
               end else begin
                  if (ir[DEST_A]) a_reg    <= alu_out;
                  if (ir[DEST_D]) d_reg    <= alu_out;
                  if (ir[DEST_M]) outm_reg <= alu_out;
                  pc_reg <= jump ? a_reg[ADDR_W-1:0] : pc_reg + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.instr_ready = instr_ready;
   assign bus.mem_req     = mem_req;
   assign bus.writeM      = writeM;
   assign bus.outM        = outm_reg;
   assign bus.pc          = pc_reg;
   assign bus.addressM    = (state == ST_WRITE) ? addr_reg : a_reg[ADDR_W-1:0];

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb/tb_hack_cpu_ctrl.sv - directed and randomized checks of hack_cpu_ctrl against an instruction-level model
module tb_hack_cpu_ctrl;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   hack_cpu_ctrl_if bus ();

   hack_cpu_ctrl dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [5:0]  comp_tbl [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                                  6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                                  6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
   logic [15:0] ram [int];
   logic [15:0] ma, md;
   logic [14:0] mpc;

   int          n_req, iters;
   logic        rd_seen, wr_seen;
   logic [14:0] rd_addr, wr_addr;
   logic [15:0] wr_data;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] hack_alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
      case (c)
         6'b101010: return 16'h0000;
         6'b111111: return 16'h0001;
         6'b111010: return 16'hFFFF;
         6'b001100: return x;
         6'b110000: return y;
         6'b001101: return ~x;
         6'b110001: return ~y;
         6'b001111: return -x;
         6'b110011: return -y;
         6'b011111: return x + 16'd1;
         6'b110111: return y + 16'd1;
         6'b001110: return x - 16'd1;
         6'b110010: return y - 16'd1;
         6'b000010: return x + y;
         6'b010011: return x - y;
         6'b000111: return y - x;
         6'b000000: return x & y;
         6'b010101: return x | y;
         default:   return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] ram_val(input logic [14:0] ad);
      if (ram.exists(int'(ad))) return ram[int'(ad)];
      return {ad, 1'b0} ^ 16'hA5C3;
   endfunction

   function automatic int pick_wait(input int mem_wait);
      return (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
   endfunction

   function automatic logic [15:0] rand_instr();
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15]) w[11:6] = comp_tbl[$urandom_range(0, 17)];
      return w;
   endfunction

   // Enter and leave at a falling edge with the controller waiting for an instruction.
   task automatic run_instr(input logic [15:0] w, input int mem_wait);
      logic [15:0] m, y, r, na, nd;
      logic [14:0] npc;
      logic        exp_rd, exp_wr, taken;
      int          waits, budget;
      exp_rd = w[15] && w[12];
      m      = exp_rd ? ram_val(ma[14:0]) : 16'h0;
      exp_wr = 1'b0;
      r      = 16'h0;
      na     = ma;
      nd     = md;
      npc    = mpc + 15'd1;
      if (!w[15]) begin
         na = w;
      end else begin
         y     = w[12] ? m : ma;
         r     = hack_alu(w[11:6], md, y);
         taken = (w[2] && r[15]) || (w[1] && r == 16'h0) || (w[0] && !r[15] && r != 16'h0);
         if (taken) npc = ma[14:0];
         if (w[5]) na = r;
         if (w[4]) nd = r;
         exp_wr = w[3];
      end

      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.instr       = w;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = 16'($urandom);
      rd_seen = 1'b0; wr_seen = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      n_req   = 0; iters = 0;
      waits   = pick_wait(mem_wait);
      budget  = 60;
      while (!bus.instr_ready && budget > 0) begin
         bus.mem_ack = 1'b0;
         if (bus.mem_req) begin
            n_req++;
            if (waits == 0) begin
               bus.mem_ack = 1'b1;
               if (bus.writeM) begin
                  wr_seen = 1'b1;
                  wr_addr = bus.addressM;
                  wr_data = bus.outM;
                  ram[int'(bus.addressM)] = bus.outM;
               end else begin
                  rd_seen = 1'b1;
                  rd_addr = bus.addressM;
                  bus.inM = ram_val(bus.addressM);
               end
               waits = pick_wait(mem_wait);
            end else begin
               waits--;
            end
         end
         iters++;
         budget--;
         @(negedge clk);
      end
      bus.mem_ack = 1'b0;

      check_eq("done", 32'(bus.instr_ready), 32'd1);
      check_eq("cycles", 32'(iters), 32'(1 + n_req));
      check_eq("pc", 32'(bus.pc), 32'(npc));
      check_eq("a", 32'(dut.a_reg), 32'(na));
      check_eq("d", 32'(dut.d_reg), 32'(nd));
      check_eq("rd_seen", 32'(rd_seen), 32'(exp_rd));
      check_eq("wr_seen", 32'(wr_seen), 32'(exp_wr));
      if (exp_rd) check_eq("rd_addr", 32'(rd_addr), 32'(ma[14:0]));
      if (exp_wr) begin
         check_eq("wr_addr", 32'(wr_addr), 32'(ma[14:0]));
         check_eq("wr_data", 32'(wr_data), 32'(r));
      end
      ma  = na;
      md  = nd;
      mpc = npc;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      ma = '0; md = '0; mpc = '0;
      rst_n           = 1'b0;
      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      bus.inM         = '0;
      bus.mem_ack     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("rst_pc", 32'(bus.pc), 32'd0);
      check_eq("rst_req", 32'(bus.mem_req), 32'd0);
      check_eq("rst_we", 32'(bus.writeM), 32'd0);
      check_eq("rst_rdy", 32'(bus.instr_ready), 32'd1);
      check_eq("rst_a", 32'(dut.a_reg), 32'd0);
      check_eq("rst_d", 32'(dut.d_reg), 32'd0);

      // @5 ; D=A
      run_instr(16'h0005, -1);
      check_eq("a_cycles", 32'(iters), 32'd1);
      run_instr(16'hEC10, -1);
      check_eq("d_eq_a", 32'(dut.d_reg), 32'd5);
      check_eq("pc_2", 32'(bus.pc), 32'd2);
      check_eq("no_req", 32'(n_req), 32'd0);

      // @100 ; D=M with slow memory
      ram[100] = 16'h1234;
      run_instr(16'd100, -1);
      run_instr(16'hFC10, 2);
      check_eq("rd_hold", 32'(n_req), 32'd3);
      check_eq("rd_at_100", 32'(rd_addr), 32'd100);
      check_eq("d_1234", 32'(dut.d_reg), 32'h1234);

      // D=7 ; @200 ; M=D
      run_instr(16'd7, -1);
      run_instr(16'hEC10, -1);
      run_instr(16'd200, -1);
      run_instr(16'hE308, 1);
      check_eq("wr_200", 32'(wr_addr), 32'd200);
      check_eq("wr_7", 32'(wr_data), 32'd7);

      // Jumps
      run_instr(16'd50, -1);
      run_instr(16'hEA87, -1);
      check_eq("jmp_50", 32'(bus.pc), 32'd50);
      run_instr(16'hEA90, -1);
      run_instr(16'd60, -1);
      run_instr(16'hE302, -1);
      check_eq("jeq_taken", 32'(bus.pc), 32'd60);
      run_instr(16'hEFD0, -1);
      run_instr(16'd70, -1);
      run_instr(16'hE302, -1);
      check_eq("jeq_not", 32'(bus.pc), 32'd63);

      // AM=A writes to the old A
      run_instr(16'd300, -1);
      run_instr(16'hEC28, 0);
      check_eq("am_addr", 32'(wr_addr), 32'd300);
      check_eq("am_data", 32'(wr_data), 32'd300);
      check_eq("am_a", 32'(dut.a_reg), 32'd300);

      // PC wrap and ignored bits 14:13
      run_instr(16'h7FFF, -1);
      run_instr(16'hEA87, -1);
      check_eq("pc_max", 32'(bus.pc), 32'h7FFF);
      run_instr(16'h0003, -1);
      check_eq("pc_wrap", 32'(bus.pc), 32'd0);
      run_instr(16'h8C10, -1);
      check_eq("c_bits", 32'(dut.d_reg), 32'd3);

      for (int i = 0; i < 200; i++) run_instr(rand_instr(), -1);

      // Reset in the middle of a stalled read; a late ack must do nothing
      run_instr(16'd100, -1);
      bus.instr       = 16'hFC10;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check_eq("stall_req", 32'(bus.mem_req), 32'd1);
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("rr_req", 32'(bus.mem_req), 32'd0);
      check_eq("rr_rdy", 32'(bus.instr_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.mem_ack = 1'b1;
      bus.inM     = 16'hBEEF;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check_eq("late_req", 32'(bus.mem_req), 32'd0);
      check_eq("late_rdy", 32'(bus.instr_ready), 32'd1);
      check_eq("late_pc", 32'(bus.pc), 32'd0);
      check_eq("late_m", 32'(dut.m_reg), 32'd0);
      check_eq("late_d", 32'(dut.d_reg), 32'd0);
      ma = '0; md = '0; mpc = '0;
      for (int i = 0; i < 20; i++) run_instr(rand_instr(), -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
